id_issue_scoreboard: RTL and testbench

ID_ISSUE_SCOREBOARD -- requirements
Module: id_issue_scoreboard

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/scoreboard.sv | 59 +++++
 rtl/id_issue_scoreboard.sv | 159 +++++++++++++++
 tb/tb_id_issue_scoreboard.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared types and helpers for the issue stage: output-register
//            state encoding and register-index width calculation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  // Occupancy of the single issue output register
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } issue_state_e;

  // Bits needed to index NREG architectural registers (never less than 1)
  function automatic int reg_idx_w(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/scoreboard.sv
// ============================================================================
// Module   : scoreboard
// Purpose  : Per-register busy bits. A bit is set when a writer issues,
//            cleared on write-back or when a held writer is flushed.
//            Set beats clear in the same cycle; register 0 is never busy.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scoreboard
  import pipe_pkg::*;
#(
  parameter int  NREG = 32,
  localparam int RW   = reg_idx_w(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_en,
  input  logic [RW-1:0]   set_idx,
  input  logic            clr_en,
  input  logic [RW-1:0]   clr_idx,
  input  logic            kill_en,
  input  logic [RW-1:0]   kill_idx,
  output logic [NREG-1:0] busy_vec
);

  generate
    for (genvar g = 0; g < NREG; g++) begin : g_bit
      if (g == 0) begin : g_zero
        // x0 is hardwired, so it can never carry a pending write
        assign busy_vec[g] = 1'b0;
      end else begin : g_reg
        logic w_set;
        logic w_clr;
        logic r_bit;

        assign w_set = set_en && (set_idx == RW'(g));
        assign w_clr = (clr_en  && (clr_idx  == RW'(g))) ||
                       (kill_en && (kill_idx == RW'(g)));

        // Busy bit: a new writer issuing this cycle outranks any clear
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_bit <= 1'b0;
          end else if (w_set) begin
            r_bit <= 1'b1;
          end else if (w_clr) begin
            r_bit <= 1'b0;
          end
        end

        assign busy_vec[g] = r_bit;
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/id_issue_scoreboard.sv
// ============================================================================
// Module   : id_issue_scoreboard
// Purpose  : Decode-to-issue stage with a register scoreboard. Holds one
//            instruction, stalls on RAW/WAW hazards, optionally bypasses
//            the current write-back onto operands, counts stall cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_issue_scoreboard
  import pipe_pkg::*;
#(
  parameter int  XLEN   = 32,
  parameter int  NREG   = 32,
  parameter int  FWD_EN = 1,
  parameter int  SCNT_W = 16,
  localparam int RW     = reg_idx_w(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [RW-1:0]     in_rs1,
  input  logic [RW-1:0]     in_rs2,
  input  logic [RW-1:0]     in_rd,
  input  logic              in_use_rs1,
  input  logic              in_use_rs2,
  input  logic              in_wr_rd,
  input  logic              in_is_load,
  input  logic [XLEN-1:0]   in_rdata1,
  input  logic [XLEN-1:0]   in_rdata2,
  input  logic              wb_valid,
  input  logic [RW-1:0]     wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_op1,
  output logic [XLEN-1:0]   out_op2,
  output logic [RW-1:0]     out_rd,
  output logic              out_wr_rd,
  output logic              out_is_load,
  output logic [NREG-1:0]   busy_vec,
  output logic [SCNT_W-1:0] stall_cnt
);

  issue_state_e      r_state;
  issue_state_e      w_state_nxt;
  logic              w_load;
  logic              w_accept;
  logic              w_hazard;
  logic              w_need1;
  logic              w_need2;
  logic              w_needd;
  logic              w_wb_clr;
  logic              w_fwd1;
  logic              w_fwd2;
  logic [NREG-1:0]   w_busy_eff;
  logic [SCNT_W-1:0] r_stall;

  assign w_need1  = in_use_rs1 && (in_rs1 != '0);
  assign w_need2  = in_use_rs2 && (in_rs2 != '0);
  assign w_needd  = in_wr_rd   && (in_rd  != '0);
  assign w_wb_clr = wb_valid   && (wb_rd  != '0);

  // Busy view for hazard detection: with bypass, a register being written
  // back right now is as good as ready
  always_comb begin
    w_busy_eff = busy_vec;
    if ((FWD_EN != 0) && w_wb_clr) begin
      w_busy_eff[wb_rd] = 1'b0;
    end
  end

  assign w_hazard = (w_need1 && w_busy_eff[in_rs1]) ||
                    (w_need2 && w_busy_eff[in_rs2]) ||
                    (w_needd && w_busy_eff[in_rd]);

  assign out_valid = (r_state == ST_FULL);
  assign in_ready  = (!out_valid || out_ready) && !w_hazard && !flush;
  assign w_accept  = in_valid && in_ready;

  assign w_fwd1 = (FWD_EN != 0) && wb_valid && (wb_rd == in_rs1) && (in_rs1 != '0);
  assign w_fwd2 = (FWD_EN != 0) && wb_valid && (wb_rd == in_rs2) && (in_rs2 != '0);

  // Next-state: flush dominates, then a fresh accept, then draining
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else if (w_accept) begin
      w_state_nxt = ST_FULL;
      w_load      = 1'b1;
    end else if ((r_state == ST_FULL) && out_ready) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  // Output-register occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Issue payload, captured only on accept so it holds under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pc      <= '0;
      out_op1     <= '0;
      out_op2     <= '0;
      out_rd      <= '0;
      out_wr_rd   <= 1'b0;
      out_is_load <= 1'b0;
    end else if (w_load) begin
      out_pc      <= in_pc;
      out_op1     <= w_fwd1 ? wb_data : in_rdata1;
      out_op2     <= w_fwd2 ? wb_data : in_rdata2;
      out_rd      <= in_rd;
      out_wr_rd   <= in_wr_rd;
      out_is_load <= in_is_load;
    end
  end

  // Saturating count of cycles a valid instruction was blocked by a hazard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else if (in_valid && w_hazard && !flush && !(&r_stall)) begin
      r_stall <= r_stall + SCNT_W'(1);
    end
  end

  assign stall_cnt = r_stall;

  // A flushed writer never reaches write-back, so its busy bit is released
  // here; no other writer to that register can be pending at the same time
  scoreboard #(
    .NREG     (NREG)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (w_accept && w_needd),
    .set_idx  (in_rd),
    .clr_en   (w_wb_clr),
    .clr_idx  (wb_rd),
    .kill_en  (flush && out_valid && out_wr_rd),
    .kill_idx (out_rd),
    .busy_vec (busy_vec)
  );

endmodule

`default_nettype wire

// File: tb/tb_id_issue_scoreboard.sv
// ============================================================================
// Module   : tb_id_issue_scoreboard
// Purpose  : Self-checking bench: a bypassing and a non-bypassing instance
//            share directed stimulus; a behavioural model predicts both.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_issue_scoreboard;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int RW     = 5;
  localparam int SCNT_W = 8;

  logic clk;
  logic rst_n;
  logic in_valid;
  logic [XLEN-1:0] in_pc;
  logic [RW-1:0] in_rs1, in_rs2, in_rd;
  logic in_use_rs1, in_use_rs2, in_wr_rd, in_is_load;
  logic [XLEN-1:0] in_rdata1, in_rdata2;
  logic wb_valid;
  logic [RW-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic flush;
  logic out_ready;

  // index 0: bypass enabled, index 1: bypass disabled
  logic [1:0]        in_ready_v, out_valid_v, out_wr_rd_v, out_is_load_v;
  logic [XLEN-1:0]   out_pc_v [2];
  logic [XLEN-1:0]   out_op1_v [2];
  logic [XLEN-1:0]   out_op2_v [2];
  logic [RW-1:0]     out_rd_v [2];
  logic [NREG-1:0]   busy_v [2];
  logic [SCNT_W-1:0] scnt_v [2];

  int total = 0;
  int bad   = 0;

  id_issue_scoreboard #(.XLEN(XLEN), .NREG(NREG), .FWD_EN(1), .SCNT_W(SCNT_W)) u_fwd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_wr_rd(in_wr_rd),
    .in_is_load(in_is_load), .in_rdata1(in_rdata1), .in_rdata2(in_rdata2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid_v[0]), .out_ready(out_ready), .out_pc(out_pc_v[0]),
    .out_op1(out_op1_v[0]), .out_op2(out_op2_v[0]), .out_rd(out_rd_v[0]),
    .out_wr_rd(out_wr_rd_v[0]), .out_is_load(out_is_load_v[0]),
    .busy_vec(busy_v[0]), .stall_cnt(scnt_v[0])
  );

  id_issue_scoreboard #(.XLEN(XLEN), .NREG(NREG), .FWD_EN(0), .SCNT_W(SCNT_W)) u_nofwd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_wr_rd(in_wr_rd),
    .in_is_load(in_is_load), .in_rdata1(in_rdata1), .in_rdata2(in_rdata2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid_v[1]), .out_ready(out_ready), .out_pc(out_pc_v[1]),
    .out_op1(out_op1_v[1]), .out_op2(out_op2_v[1]), .out_rd(out_rd_v[1]),
    .out_wr_rd(out_wr_rd_v[1]), .out_is_load(out_is_load_v[1]),
    .busy_vec(busy_v[1]), .stall_cnt(scnt_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- checking
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------------ model
  // Set of registers with an outstanding writer, plus the held instruction.
  logic [NREG-1:0]   m_busy [2];
  logic              m_full [2];
  logic [XLEN-1:0]   m_pc [2];
  logic [XLEN-1:0]   m_op1 [2];
  logic [XLEN-1:0]   m_op2 [2];
  logic [RW-1:0]     m_rd [2];
  logic              m_wr [2];
  logic              m_ld [2];
  logic [SCNT_W-1:0] m_scnt [2];

  // A register blocks issue if someone still owes it a value, unless the
  // bypassing variant sees that value arriving on write-back right now.
  function automatic bit m_blocked(int k, logic [RW-1:0] idx, logic used);
    if (!used || idx == 0)   return 1'b0;
    if (!m_busy[k][idx])     return 1'b0;
    if (k == 0 && wb_valid && wb_rd == idx) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_hazard(int k);
    return m_blocked(k, in_rs1, in_use_rs1) || m_blocked(k, in_rs2, in_use_rs2) ||
           m_blocked(k, in_rd, in_wr_rd);
  endfunction

  function automatic bit m_ready(int k);
    return (!m_full[k] || out_ready) && !m_hazard(k) && !flush;
  endfunction

  function automatic logic [XLEN-1:0] m_opnd(int k, logic [RW-1:0] idx, logic [XLEN-1:0] rf);
    if (k == 0 && wb_valid && wb_rd == idx && idx != 0) return wb_data;
    return rf;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] <= '0; m_full[k] <= 1'b0; m_pc[k] <= '0; m_op1[k] <= '0;
        m_op2[k] <= '0; m_rd[k] <= '0; m_wr[k] <= 1'b0; m_ld[k] <= 1'b0;
        m_scnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic [NREG-1:0] nb;
        bit acc;
        acc = in_valid && m_ready(k);
        nb  = m_busy[k];
        if (wb_valid && wb_rd != 0) nb[wb_rd] = 1'b0;
        if (flush && m_full[k] && m_wr[k] && m_rd[k] != 0) nb[m_rd[k]] = 1'b0;
        if (acc && in_wr_rd && in_rd != 0) nb[in_rd] = 1'b1;
        m_busy[k] <= nb;
        if (in_valid && m_hazard(k) && !flush && m_scnt[k] != {SCNT_W{1'b1}})
          m_scnt[k] <= m_scnt[k] + 1'b1;
        if (flush) begin
          m_full[k] <= 1'b0;
        end else if (acc) begin
          m_full[k] <= 1'b1;
          m_pc[k]   <= in_pc;
          m_op1[k]  <= m_opnd(k, in_rs1, in_rdata1);
          m_op2[k]  <= m_opnd(k, in_rs2, in_rdata2);
          m_rd[k]   <= in_rd;
          m_wr[k]   <= in_wr_rd;
          m_ld[k]   <= in_is_load;
        end else if (out_ready) begin
          m_full[k] <= 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison, 2 time units after inputs change on the negedge
  always @(negedge clk) begin
    #2;
    for (int k = 0; k < 2; k++) begin
      string nm;
      nm = (k == 0) ? "fwd" : "nofwd";
      chk($sformatf("cyc %s in_ready", nm),  {31'd0, in_ready_v[k]},  {31'd0, m_ready(k)});
      chk($sformatf("cyc %s out_valid", nm), {31'd0, out_valid_v[k]}, {31'd0, m_full[k]});
      chk($sformatf("cyc %s busy_vec", nm),  busy_v[k], m_busy[k]);
      chk($sformatf("cyc %s stall_cnt", nm), {24'd0, scnt_v[k]}, {24'd0, m_scnt[k]});
      chk($sformatf("cyc %s out_pc", nm),    out_pc_v[k],  m_pc[k]);
      chk($sformatf("cyc %s out_op1", nm),   out_op1_v[k], m_op1[k]);
      chk($sformatf("cyc %s out_op2", nm),   out_op2_v[k], m_op2[k]);
      chk($sformatf("cyc %s out_rd", nm),    {27'd0, out_rd_v[k]}, {27'd0, m_rd[k]});
      chk($sformatf("cyc %s out_flags", nm), {30'd0, out_wr_rd_v[k], out_is_load_v[k]},
                                             {30'd0, m_wr[k], m_ld[k]});
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic drv(input logic v, input logic [XLEN-1:0] pc, input logic [RW-1:0] rs1,
                     input logic [RW-1:0] rs2, input logic [RW-1:0] rd, input logic u1,
                     input logic u2, input logic wr, input logic ld);
    in_valid = v; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_use_rs1 = u1; in_use_rs2 = u2; in_wr_rd = wr; in_is_load = ld;
    in_rdata1 = 32'hA000_0000 | {27'd0, rs1};
    in_rdata2 = 32'hB000_0000 | {27'd0, rs2};
  endtask

  task automatic wbk(input logic v, input logic [RW-1:0] rd, input logic [XLEN-1:0] d);
    wb_valid = v; wb_rd = rd; wb_data = d;
  endtask

  task automatic idle();
    drv(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    idle(); wbk(1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk); #3;
    for (int k = 0; k < 2; k++) begin
      chk("reset out_valid", {31'd0, out_valid_v[k]}, 32'd0);
      chk("reset busy_vec",  busy_v[k], 32'd0);
      chk("reset stall_cnt", {24'd0, scnt_v[k]}, 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;

    // RAW on x5, resolved by write-back of 0x1234
    @(negedge clk); drv(1, 32'h100, 1, 2, 5, 1, 1, 1, 0); #3;
    chk("A1 fwd in_ready", {31'd0, in_ready_v[0]}, 32'd1);
    chk("A1 nofwd in_ready", {31'd0, in_ready_v[1]}, 32'd1);
    @(negedge clk); drv(1, 32'h104, 5, 0, 6, 1, 0, 1, 0); #3;
    chk("A2 fwd out_pc", out_pc_v[0], 32'h100);
    chk("A2 fwd busy_vec", busy_v[0], 32'h0000_0020);
    chk("A2 fwd in_ready", {31'd0, in_ready_v[0]}, 32'd0);
    @(negedge clk); #3;
    chk("A3 fwd stall_cnt", {24'd0, scnt_v[0]}, 32'd1);
    chk("A3 fwd out_valid", {31'd0, out_valid_v[0]}, 32'd0);
    @(negedge clk); wbk(1, 5, 32'h1234); #3;
    chk("A4 fwd in_ready", {31'd0, in_ready_v[0]}, 32'd1);
    chk("A4 nofwd in_ready", {31'd0, in_ready_v[1]}, 32'd0);
    @(negedge clk); wbk(0, 0, 0); #3;
    chk("A5 fwd out_op1", out_op1_v[0], 32'h1234);
    chk("A5 fwd out_pc", out_pc_v[0], 32'h104);
    chk("A5 nofwd in_ready", {31'd0, in_ready_v[1]}, 32'd1);
    chk("A5 nofwd stall_cnt", {24'd0, scnt_v[1]}, 32'd3);
    @(negedge clk); idle(); wbk(1, 6, 0); #3;
    chk("A6 nofwd out_valid", {31'd0, out_valid_v[1]}, 32'd1);
    chk("A6 nofwd out_op1", out_op1_v[1], 32'hA000_0005);
    chk("A6 fwd busy_vec", busy_v[0], 32'h0000_0040);

    // WAW on x7
    @(negedge clk); wbk(0, 0, 0); drv(1, 32'h200, 0, 0, 7, 0, 0, 1, 0); #3;
    chk("B1 fwd in_ready", {31'd0, in_ready_v[0]}, 32'd1);
    @(negedge clk); drv(1, 32'h204, 0, 0, 7, 0, 0, 1, 1); #3;
    chk("B2 fwd in_ready", {31'd0, in_ready_v[0]}, 32'd0);
    chk("B2 fwd busy_vec", busy_v[0], 32'h0000_0080);
    @(negedge clk); wbk(1, 7, 32'h77); #3;
    chk("B3 fwd in_ready", {31'd0, in_ready_v[0]}, 32'd1);
    chk("B3 nofwd in_ready", {31'd0, in_ready_v[1]}, 32'd0);
    @(negedge clk); wbk(0, 0, 0); #3;
    chk("B4 fwd busy_vec", busy_v[0], 32'h0000_0080);
    chk("B4 fwd out_pc", out_pc_v[0], 32'h204);
    chk("B4 fwd out_is_load", {31'd0, out_is_load_v[0]}, 32'd1);
    chk("B4 nofwd in_ready", {31'd0, in_ready_v[1]}, 32'd1);
    @(negedge clk); idle(); #3;
    chk("B5 nofwd busy_vec", busy_v[1], 32'h0000_0080);
    chk("B5 nofwd out_pc", out_pc_v[1], 32'h204);
    @(negedge clk); wbk(1, 7, 0);
    @(negedge clk); wbk(0, 0, 0);

    // Flush a held writer to x3
    @(negedge clk); out_ready = 1'b0; drv(1, 32'h300, 0, 0, 3, 0, 0, 1, 0);
    @(negedge clk); idle(); flush = 1'b1; #3;
    chk("C2 fwd out_valid", {31'd0, out_valid_v[0]}, 32'd1);
    chk("C2 fwd busy_vec", busy_v[0], 32'h0000_0008);
    chk("C2 fwd in_ready", {31'd0, in_ready_v[0]}, 32'd0);
    @(negedge clk); flush = 1'b0; out_ready = 1'b1; #3;
    chk("C3 fwd out_valid", {31'd0, out_valid_v[0]}, 32'd0);
    chk("C3 fwd busy_vec", busy_v[0], 32'd0);
    chk("C3 nofwd busy_vec", busy_v[1], 32'd0);

    // Writer to x0 reading x0: never stalls
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drv(1, 32'h400 + 32'(4 * i), 0, 0, 0, 1, 1, 1, 0); #3;
      chk("D fwd in_ready", {31'd0, in_ready_v[0]}, 32'd1);
      chk("D nofwd in_ready", {31'd0, in_ready_v[1]}, 32'd1);
      chk("D fwd busy_vec", busy_v[0], 32'd0);
    end

    // Permanent hazard on x9: saturate the stall counter, then reset
    @(negedge clk); drv(1, 32'h500, 0, 0, 9, 0, 0, 1, 0);
    @(negedge clk); drv(1, 32'h504, 9, 0, 10, 1, 0, 1, 0);
    repeat ((1 << SCNT_W) + 5) @(negedge clk);
    #3;
    chk("E fwd stall_cnt sat", {24'd0, scnt_v[0]}, 32'h0000_00FF);
    chk("E nofwd stall_cnt sat", {24'd0, scnt_v[1]}, 32'h0000_00FF);
    chk("E fwd in_ready", {31'd0, in_ready_v[0]}, 32'd0);
    @(negedge clk); rst_n = 1'b0; #3;
    for (int k = 0; k < 2; k++) begin
      chk("E rst out_valid", {31'd0, out_valid_v[k]}, 32'd0);
      chk("E rst busy_vec", busy_v[k], 32'd0);
      chk("E rst stall_cnt", {24'd0, scnt_v[k]}, 32'd0);
      chk("E rst out_pc", out_pc_v[k], 32'd0);
      chk("E rst out_op1", out_op1_v[k], 32'd0);
      chk("E rst out_op2", out_op2_v[k], 32'd0);
      chk("E rst out_rd_flags", {25'd0, out_rd_v[k], out_wr_rd_v[k], out_is_load_v[k]}, 32'd0);
    end
    @(negedge clk); rst_n = 1'b1; #3;
    chk("E rel fwd in_ready", {31'd0, in_ready_v[0]}, 32'd1);
    chk("E rel nofwd in_ready", {31'd0, in_ready_v[1]}, 32'd1);
    @(negedge clk); idle(); #3;
    chk("E rel fwd out_pc", out_pc_v[0], 32'h504);
    chk("E rel fwd busy_vec", busy_v[0], 32'h0000_0400);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
